// File: rtl/order_content_reader_if.sv
// Port-A request, RAM and output-stream signals of the order-content reader.
// The master modport is the reader's view; slave is the surrounding logic.
interface order_content_reader_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 793,
  parameter int TDATA_WIDTH = 256
);
  logic                     wr_req_valid;
  logic                     wr_req_ready;
  logic [ADDR_WIDTH-1:0]    wr_req_addr;
  logic [DATA_WIDTH-1:0]    wr_req_data;
  logic                     rd_req_valid;
  logic                     rd_req_ready;
  logic [ADDR_WIDTH-1:0]    rd_req_addr;
  logic [ADDR_WIDTH-1:0]    ram_addr;
  logic [DATA_WIDTH-1:0]    ram_din;
  logic                     ram_we;
  logic [DATA_WIDTH-1:0]    ram_dout;
  logic [TDATA_WIDTH-1:0]   m_axis_tdata;
  logic [TDATA_WIDTH/8-1:0] m_axis_tkeep;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic [31:0]              rd_done_count;

  modport master (
    input  wr_req_valid, wr_req_addr, wr_req_data,
    input  rd_req_valid, rd_req_addr,
    input  ram_dout, m_axis_tready,
    output wr_req_ready, rd_req_ready,
    output ram_addr, ram_din, ram_we,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output rd_done_count
  );

  modport slave (
    output wr_req_valid, wr_req_addr, wr_req_data,
    output rd_req_valid, rd_req_addr,
    output ram_dout, m_axis_tready,
    input  wr_req_ready, rd_req_ready,
    input  ram_addr, ram_din, ram_we,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  rd_done_count
  );
endinterface

// File: rtl/order_content_reader.sv
// Port-A master for the order-content RAM: writes win arbitration, each read
// record is captured and streamed as TDATA_WIDTH-bit AXI-Stream beats.
module order_content_reader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 793,
  parameter int TDATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  order_content_reader_if.master bus
);
  localparam int BEATS      = (DATA_WIDTH + TDATA_WIDTH - 1) / TDATA_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_WIDTH  = BEATS * TDATA_WIDTH;
  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int LAST_BITS  = DATA_WIDTH - (BEATS - 1) * TDATA_WIDTH;
  localparam int LAST_BYTES = (LAST_BITS + 7) / 8;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP = KEEP_WIDTH'((64'd1 << LAST_BYTES) - 64'd1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, SEND} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [BEAT_W-1:0]     r_beat;
  logic [BEAT_W-1:0]     w_beat_next;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [31:0]           r_done_count;

  logic                  w_rd_issue;
  logic                  w_wr_accept;
  logic                  w_beat_fire;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [PAD_WIDTH-1:0]  w_padded;

  assign w_padded    = PAD_WIDTH'(r_buf);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_fire = (r_state == SEND) && bus.m_axis_tready;

  // Handshakes are gated by reset so the RAM sees no strobes while held in reset.
  always_comb begin
    w_rd_issue   = !reset && (r_state == IDLE) && bus.rd_req_valid && !bus.wr_req_valid;
    w_wr_accept  = !reset && bus.wr_req_valid && !((r_state == IDLE) && w_rd_issue);
    w_state_next = r_state;
    w_beat_next  = r_beat;
    case (r_state)
      IDLE:    if (w_rd_issue) w_state_next = RD_WAIT;
      RD_WAIT: begin
        w_state_next = SEND;
        w_beat_next  = '0;
      end
      SEND: begin
        if (w_beat_fire) begin
          if (w_last_beat) w_state_next = IDLE;
          else             w_beat_next  = r_beat + BEAT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_ram_addr  = '0;
    bus.ram_din = '0;
    if (w_wr_accept) begin
      w_ram_addr  = bus.wr_req_addr;
      bus.ram_din = bus.wr_req_data;
    end else if (w_rd_issue) begin
      w_ram_addr  = bus.rd_req_addr;
    end
  end

  assign bus.ram_addr      = w_ram_addr;
  assign bus.ram_we        = w_wr_accept;
  assign bus.wr_req_ready  = w_wr_accept;
  assign bus.rd_req_ready  = w_rd_issue;
  assign bus.rd_done_count = r_done_count;

  // The final beat carries the record tail zero-padded to the full bus width.
  always_comb begin
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tkeep  = '0;
    bus.m_axis_tlast  = 1'b0;
    if (!reset && (r_state == SEND)) begin
      bus.m_axis_tvalid = 1'b1;
      bus.m_axis_tlast  = w_last_beat;
      bus.m_axis_tkeep  = w_last_beat ? LAST_KEEP : '1;
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (r_beat == BEAT_W'(i)) bus.m_axis_tdata = w_padded[i*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_buf        <= '0;
      r_done_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
      // RAM output reflects the address sampled at the accept edge, so a
      // same-address write during this cycle still yields the old record.
      if (r_state == RD_WAIT) r_buf <= bus.ram_dout;
      if (w_beat_fire && w_last_beat) r_done_count <= r_done_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_order_content_reader.sv
// Self-checking bench for order_content_reader: arbitration table, directed
// multi-cycle sequences and randomized traffic against a record-level model.
module tb_order_content_reader;
  localparam int AW = 12;
  localparam int DW = 793;
  localparam int TW = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic          rdv = 1'b0, wrv = 1'b0, tready = 1'b0;
  logic [AW-1:0] raddr = '0, waddr = '0;
  logic [DW-1:0] wdata = '0;

  order_content_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TDATA_WIDTH(TW)) bus ();

  order_content_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TDATA_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.wr_req_valid  = wrv;
  assign bus.wr_req_addr   = waddr;
  assign bus.wr_req_data   = wdata;
  assign bus.rd_req_valid  = rdv;
  assign bus.rd_req_addr   = raddr;
  assign bus.m_axis_tready = tready;

  // Registered-output, read-first block RAM behind port A.
  logic [DW-1:0] ram [4096];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    ram_q <= ram[bus.ram_addr];
  end
  assign bus.ram_dout = ram_q;

  // Record-level reference model.
  logic [DW-1:0] m_mem [4096];
  logic [DW-1:0] m_rec;
  logic          m_busy = 1'b0;
  int            m_age = 0;
  int            m_beats = 0;
  logic [31:0]   m_count = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] beat_of(input logic [DW-1:0] rec, input int b);
    logic [255:0] r;
    logic [9:0]   idx;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      idx = 10'(b * 256 + i);
      if (int'(idx) < DW) r[i] = rec[idx];
    end
    return r;
  endfunction

  function automatic logic [31:0] keep_of(input int b);
    logic [31:0] k;
    k = '0;
    for (int j = 0; j < 32; j++) if (b * 256 + j * 8 < DW) k[j] = 1'b1;
    return k;
  endfunction

  function automatic logic [DW-1:0] rand_rec();
    logic [831:0] t;
    t = '0;
    for (int i = 0; i < 26; i++) t = {t[799:0], 32'($urandom())};
    return t[DW-1:0];
  endfunction

  // One clock cycle: called at negedge with inputs set; checks, commits, updates model.
  task automatic step();
    logic          e_rr, e_v;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    #1;
    e_rr   = !m_busy && rdv && !wrv;
    e_addr = wrv ? waddr : (e_rr ? raddr : '0);
    e_din  = wrv ? wdata : '0;
    e_v    = m_busy && (m_age >= 1);
    chk("rd_req_ready", 256'(bus.rd_req_ready), 256'(e_rr));
    chk("wr_req_ready", 256'(bus.wr_req_ready), 256'(wrv));
    chk("ram_we", 256'(bus.ram_we), 256'(wrv));
    chk("ram_addr", 256'(bus.ram_addr), 256'(e_addr));
    chk("ram_din_match", 256'(bus.ram_din === e_din), 256'd1);
    chk("tvalid", 256'(bus.m_axis_tvalid), 256'(e_v));
    if (e_v) begin
      chk("tdata", bus.m_axis_tdata, beat_of(m_rec, m_beats));
      chk("tkeep", 256'(bus.m_axis_tkeep), 256'(keep_of(m_beats)));
      chk("tlast", 256'(bus.m_axis_tlast), 256'(m_beats == 3));
    end
    chk("rd_done_count", 256'(bus.rd_done_count), 256'(m_count));
    @(posedge clk);
    if (wrv) m_mem[waddr] = wdata;
    if (e_rr) begin
      m_busy = 1'b1; m_age = 0; m_beats = 0; m_rec = m_mem[raddr];
    end else if (m_busy) begin
      if (e_v && tready) begin
        m_beats++;
        if (m_beats == 4) begin m_busy = 1'b0; m_count++; end
      end
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    tready = 1'b1; rdv = 1'b0; wrv = 1'b0;
    while (m_busy && n < 20) begin step(); n++; end
    if (m_busy) begin
      checks++; failures++;
      $display("FAIL drain_timeout: record in flight after %0d cycles, required none", n);
    end
  endtask

  task automatic do_reset();
    rdv = 1'b1; wrv = 1'b1; raddr = 12'h123; waddr = 12'h456; wdata = rand_rec(); tready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_tvalid", 256'(bus.m_axis_tvalid), 256'd0);
    chk("rst_tlast", 256'(bus.m_axis_tlast), 256'd0);
    chk("rst_tdata", bus.m_axis_tdata, 256'd0);
    chk("rst_tkeep", 256'(bus.m_axis_tkeep), 256'd0);
    chk("rst_rd_ready", 256'(bus.rd_req_ready), 256'd0);
    chk("rst_wr_ready", 256'(bus.wr_req_ready), 256'd0);
    chk("rst_ram_we", 256'(bus.ram_we), 256'd0);
    chk("rst_ram_addr", 256'(bus.ram_addr), 256'd0);
    chk("rst_ram_din_zero", 256'(bus.ram_din == '0), 256'd1);
    chk("rst_count", 256'(bus.rd_done_count), 256'd0);
    m_busy = 1'b0; m_age = 0; m_beats = 0; m_count = '0;
    @(posedge clk);
    @(negedge clk);
    rdv = 1'b0; wrv = 1'b0; reset = 1'b0;
  endtask

  typedef struct {
    logic          rst, rv, wv;
    logic [AW-1:0] ra, wa;
    logic          e_rr, e_wr, e_we;
    logic [AW-1:0] e_addr;
  } vec_t;

  initial begin
    vec_t          vt [6];
    logic [AW-1:0] pool [7];
    logic [DW-1:0] rec, old_fff;
    logic [255:0]  hold_d;
    logic [31:0]   hold_k;
    logic          hold_l, seen_last;
    logic [31:0]   base;
    int            gap;

    vt[0] = '{1'b1, 1'b1, 1'b1, 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[1] = '{1'b1, 1'b1, 1'b0, 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[2] = '{1'b0, 1'b0, 1'b0, 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[3] = '{1'b0, 1'b1, 1'b0, 12'h123, 12'h456, 1'b1, 1'b0, 1'b0, 12'h123};
    vt[4] = '{1'b0, 1'b0, 1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 1'b1, 12'h456};
    vt[5] = '{1'b0, 1'b1, 1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 1'b1, 12'h456};
    pool = '{12'h000, 12'h001, 12'h005, 12'h007, 12'h020, 12'hFFF, 12'h7A5};

    @(negedge clk);
    do_reset();

    // Combinational arbitration table, applied within one low clock phase.
    for (int v = 0; v < 6; v++) begin
      reset = vt[v].rst; rdv = vt[v].rv; wrv = vt[v].wv; raddr = vt[v].ra; waddr = vt[v].wa;
      #1;
      chk($sformatf("vec%0d_rd_ready", v), 256'(bus.rd_req_ready), 256'(vt[v].e_rr));
      chk($sformatf("vec%0d_wr_ready", v), 256'(bus.wr_req_ready), 256'(vt[v].e_wr));
      chk($sformatf("vec%0d_ram_we", v), 256'(bus.ram_we), 256'(vt[v].e_we));
      chk($sformatf("vec%0d_ram_addr", v), 256'(bus.ram_addr), 256'(vt[v].e_addr));
    end
    reset = 1'b0; rdv = 1'b0; wrv = 1'b0;
    @(negedge clk);

    // Preload every address that is read later.
    for (int p = 0; p < 7; p++) begin
      wrv = 1'b1; waddr = pool[p]; wdata = rand_rec();
      if (pool[p] == 12'hFFF) old_fff = wdata;
      step();
    end
    wrv = 1'b0;

    // Edge bits of a record map to beat 0 bit 0 and beat 3 bit 24.
    rec = '0; rec[0] = 1'b1; rec[DW-1] = 1'b1;
    wrv = 1'b1; waddr = 12'h005; wdata = rec; step();
    wrv = 1'b0; rdv = 1'b1; raddr = 12'h005; tready = 1'b1; step();
    rdv = 1'b0; step();
    chk("t1_b0_tdata", bus.m_axis_tdata, 256'd1);
    chk("t1_b0_tkeep", 256'(bus.m_axis_tkeep), 256'hFFFFFFFF);
    step(); step(); step();
    chk("t1_b3_tdata", bus.m_axis_tdata, 256'h01000000);
    chk("t1_b3_tkeep", 256'(bus.m_axis_tkeep), 256'hF);
    chk("t1_b3_tlast", 256'(bus.m_axis_tlast), 256'd1);
    step();
    chk("t1_count", 256'(bus.rd_done_count), 256'd1);

    // Simultaneous write and read: write wins, read follows.
    rdv = 1'b1; wrv = 1'b1; raddr = 12'h020; waddr = 12'h010; wdata = rand_rec();
    #1;
    chk("t2_ram_we", 256'(bus.ram_we), 256'd1);
    chk("t2_rd_ready", 256'(bus.rd_req_ready), 256'd0);
    step();
    wrv = 1'b0; step();
    rdv = 1'b0; step();
    chk("t2_latency_tvalid", 256'(bus.m_axis_tvalid), 256'd1);
    drain();

    // Write to the read address during the wait cycle returns old data.
    rdv = 1'b1; raddr = 12'hFFF; tready = 1'b1; step();
    rdv = 1'b0; wrv = 1'b1; waddr = 12'hFFF; wdata = '1; step();
    wrv = 1'b0;
    chk("t3_old_b0", bus.m_axis_tdata, beat_of(old_fff, 0));
    drain();
    rdv = 1'b1; raddr = 12'hFFF; step();
    rdv = 1'b0; step(); step(); step(); step();
    chk("t3_new_b3", bus.m_axis_tdata, 256'h1FFFFFF);
    chk("t3_new_b3_tkeep", 256'(bus.m_axis_tkeep), 256'hF);
    drain();

    // Backpressure stall at beat 1 with writes flowing.
    rdv = 1'b1; raddr = 12'h007; tready = 1'b1; step();
    rdv = 1'b0; step(); step();
    tready = 1'b0;
    hold_d = bus.m_axis_tdata; hold_k = bus.m_axis_tkeep; hold_l = bus.m_axis_tlast;
    chk("t4_b1_tdata", hold_d, beat_of(m_mem[12'h007], 1));
    for (int i = 0; i < 5; i++) begin
      wrv = 1'b1; waddr = 12'(12'h100 + i); wdata = rand_rec();
      step();
      chk("t4_hold_tvalid", 256'(bus.m_axis_tvalid), 256'd1);
      chk("t4_hold_tdata", bus.m_axis_tdata, hold_d);
      chk("t4_hold_tkeep", 256'(bus.m_axis_tkeep), 256'(hold_k));
      chk("t4_hold_tlast", 256'(bus.m_axis_tlast), 256'(hold_l));
    end
    wrv = 1'b0; tready = 1'b1; step();
    chk("t4_b2_tdata", bus.m_axis_tdata, beat_of(m_mem[12'h007], 2));
    step();
    chk("t4_b3_tlast", 256'(bus.m_axis_tlast), 256'd1);
    step();
    rdv = 1'b1; raddr = 12'h104; step();
    drain();

    // Reset during beat 2 drops the stream and clears the count.
    rdv = 1'b1; raddr = 12'h007; tready = 1'b1; step();
    rdv = 1'b0; step(); step(); step();
    chk("t5_at_beat2_tvalid", 256'(bus.m_axis_tvalid), 256'd1);
    do_reset();
    chk("t5_post_tvalid", 256'(bus.m_axis_tvalid), 256'd0);
    rdv = 1'b1; raddr = 12'h007; step();
    drain();
    chk("t5_count", 256'(bus.rd_done_count), 256'd1);

    // Back-to-back reads: two idle cycles between records.
    base = m_count;
    rdv = 1'b1; raddr = 12'h7A5; wrv = 1'b0; tready = 1'b1;
    gap = 0; seen_last = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (bus.m_axis_tvalid) begin
        if (seen_last) begin
          chk("t6_gap", 256'(gap), 256'd2);
          seen_last = 1'b0;
        end
        if (bus.m_axis_tlast) seen_last = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
      step();
    end
    chk("t6_records", 256'(bus.rd_done_count), 256'(base + 32'd3));
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rdv    = 1'($urandom_range(0, 1));
      wrv    = ($urandom_range(0, 3) == 0);
      raddr  = pool[$urandom_range(0, 6)];
      waddr  = pool[$urandom_range(0, 6)];
      wdata  = rand_rec();
      tready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
